// File: rtl/keypad_pkg.sv
// -----------------------------------------------------------------------------
// keypad_pkg
// Shared definitions for the 4x4 matrix keypad scanner.
//   NUM_ROWS / NUM_COLS : keypad matrix dimensions
//   scanState_e         : classification of one complete scan
//                         (no key, exactly one key, several keys)
//   KEY_MAP             : press-map bit index (row*4 + col) -> hex key code
// -----------------------------------------------------------------------------
package keypad_pkg;

   localparam int NUM_ROWS = 4;
   localparam int NUM_COLS = 4;

   typedef enum logic [1:0] {
      SCAN_NONE   = 2'd0,
      SCAN_SINGLE = 2'd1,
      SCAN_MULTI  = 2'd2
   } scanState_e;

   // Physical PmodKYPD legend, row by row, column 0 on the left:
   //   r0: 1 2 3 A | r1: 4 5 6 B | r2: 7 8 9 C | r3: 0 F E D
   localparam logic [3:0] KEY_MAP [0:15] = '{
      4'h1, 4'h2, 4'h3, 4'hA,
      4'h4, 4'h5, 4'h6, 4'hB,
      4'h7, 4'h8, 4'h9, 4'hC,
      4'h0, 4'hF, 4'hE, 4'hD
   };

endpackage

// File: rtl/keypad_debounce.sv
// -----------------------------------------------------------------------------
// keypad_debounce
// Accepts a new keypad state only after it has been seen in DEBOUNCE_SCANS
// consecutive identical full scans, then reports it as registered outputs.
// Ports:
//   clk, reset       : system clock, asynchronous active-high reset
//   scanDone_i       : one-cycle strobe, a complete scan snapshot is present
//   snapState_i      : snapshot classification (none / single / multi)
//   snapCode_i       : hex code of the single key (ignored otherwise)
//   keyCode_o        : code of the accepted key, held after release
//   keyValid_o       : high while an accepted single key is held
//   keyPress_o       : one-cycle pulse when a new key is accepted
//   keyRelease_o     : one-cycle pulse when the accepted state returns to none
// -----------------------------------------------------------------------------
module keypad_debounce
   import keypad_pkg::*;
#(
   parameter int DEBOUNCE_SCANS = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       scanDone_i,
   input  scanState_e snapState_i,
   input  logic [3:0] snapCode_i,
   output logic [3:0] keyCode_o,
   output logic       keyValid_o,
   output logic       keyPress_o,
   output logic       keyRelease_o
);

   // The count only ever has to reach DEBOUNCE_SCANS-1
   localparam int CW = (DEBOUNCE_SCANS > 1) ? $clog2(DEBOUNCE_SCANS) : 1;

   scanState_e    candState_q, candState_d;
   logic [3:0]    candCode_q, candCode_d;
   logic [CW-1:0] count_q, count_d, countInc;
   logic [3:0]    keyCode_q, keyCode_d;
   logic          keyValid_q, keyValid_d;
   logic          keyPress_q, keyPress_d;
   logic          keyRelease_q, keyRelease_d;
   logic          matchStable, matchCand, accept;

   // The stable state is the accepted output itself: keyValid_q says whether
   // a key is held and keyCode_q which one. A finished scan is compared
   // against it and against the candidate that is being debounced. Whenever
   // the scan shows the stable state or ghosting, the candidate is dropped so
   // that only back-to-back identical scans can ever build up a count.
   always_comb begin
      candState_d  = candState_q;
      candCode_d   = candCode_q;
      count_d      = count_q;
      keyCode_d    = keyCode_q;
      keyValid_d   = keyValid_q;
      keyPress_d   = 1'b0;
      keyRelease_d = 1'b0;
      accept       = 1'b0;
      countInc     = count_q + CW'(1);
      matchStable  = (snapState_i == SCAN_NONE) ? !keyValid_q
                                                : (keyValid_q && (snapCode_i == keyCode_q));
      matchCand    = (snapState_i == candState_q) &&
                     ((snapState_i == SCAN_NONE) || (snapCode_i == candCode_q));

      if (scanDone_i) begin
         if (snapState_i == SCAN_MULTI) begin
            candState_d = SCAN_MULTI;
            count_d     = '0;
         end else if (matchStable) begin
            candState_d = snapState_i;
            candCode_d  = snapCode_i;
            count_d     = '0;
         end else if (matchCand) begin
            if (countInc >= CW'(DEBOUNCE_SCANS - 1)) begin
               accept  = 1'b1;
               count_d = '0;
            end else begin
               count_d = countInc;
            end
         end else begin
            candState_d = snapState_i;
            candCode_d  = snapCode_i;
            count_d     = '0;
            if (DEBOUNCE_SCANS == 1) begin
               accept = 1'b1;
            end
         end

         if (accept) begin
            if (snapState_i == SCAN_SINGLE) begin
               keyCode_d  = snapCode_i;
               keyValid_d = 1'b1;
               keyPress_d = 1'b1;
            end else begin
               keyValid_d   = 1'b0;
               keyRelease_d = 1'b1;
            end
         end
      end
   end

   // Register everything so the outputs change the cycle after the scan
   // that decided them, and every pulse is exactly one clock wide.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         candState_q  <= SCAN_NONE;
         candCode_q   <= 4'd0;
         count_q      <= '0;
         keyCode_q    <= 4'd0;
         keyValid_q   <= 1'b0;
         keyPress_q   <= 1'b0;
         keyRelease_q <= 1'b0;
      end else begin
         candState_q  <= candState_d;
         candCode_q   <= candCode_d;
         count_q      <= count_d;
         keyCode_q    <= keyCode_d;
         keyValid_q   <= keyValid_d;
         keyPress_q   <= keyPress_d;
         keyRelease_q <= keyRelease_d;
      end
   end

   assign keyCode_o    = keyCode_q;
   assign keyValid_o   = keyValid_q;
   assign keyPress_o   = keyPress_q;
   assign keyRelease_o = keyRelease_q;

endmodule

// File: rtl/keypad_scanner.sv
// -----------------------------------------------------------------------------
// keypad_scanner
// Scans a 4x4 PmodKYPD matrix by strobing one column low at a time, reads
// the active-low rows, builds a 16-bit press map per full scan, classifies
// it and hands the result to keypad_debounce.
// Ports:
//   clk          : system clock
//   reset        : asynchronous active-high reset
//   row[3:0]     : keypad rows, active low, asynchronous to clk
//   col[3:0]     : column strobes, active low, exactly one low at a time
//   key_code     : hex code of the accepted key, held after release
//   key_valid    : high while an accepted single key is held
//   key_press    : one-cycle pulse on a newly accepted key
//   key_release  : one-cycle pulse when the accepted state returns to none
// -----------------------------------------------------------------------------
module keypad_scanner
   import keypad_pkg::*;
#(
   parameter int SCAN_BITS      = 16,
   parameter int DEBOUNCE_SCANS = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] row,
   output logic [3:0] col,
   output logic [3:0] key_code,
   output logic       key_valid,
   output logic       key_press,
   output logic       key_release
);

   logic [3:0]           rowMeta_q, rowSync_q;
   logic [SCAN_BITS-1:0] dwellCnt_q;
   logic [1:0]           colIdx_q;
   logic [15:0]          pressMap_q, pressMap_d;
   logic                 tick, scanDone;
   logic [1:0]           hitCount;
   logic [3:0]           hitIdx;
   scanState_e           snapState;
   logic [3:0]           snapCode;

   assign tick     = &dwellCnt_q;
   assign scanDone = tick && (colIdx_q == 2'd3);
   assign col      = ~(4'b0001 << colIdx_q);

   // Merge the current column's rows into the press map. This merged map is
   // also what gets classified on the column-3 tick, so the final column is
   // part of the snapshot without waiting an extra cycle. The hit count
   // saturates at two since only none/one/many matters.
   always_comb begin
      pressMap_d = pressMap_q;
      for (int r = 0; r < NUM_ROWS; r++) begin
         pressMap_d[r * NUM_COLS + int'(colIdx_q)] = ~rowSync_q[r];
      end

      hitCount = 2'd0;
      hitIdx   = 4'd0;
      for (int i = 0; i < 16; i++) begin
         if (pressMap_d[i]) begin
            if (hitCount != 2'd2) begin
               hitCount = hitCount + 2'd1;
            end
            hitIdx = 4'(i);
         end
      end

      case (hitCount)
         2'd0:    snapState = SCAN_NONE;
         2'd1:    snapState = SCAN_SINGLE;
         default: snapState = SCAN_MULTI;
      endcase
      snapCode = KEY_MAP[hitIdx];
   end

   // Two-flop row synchronizer, the free-running dwell counter and the column
   // index. Reset clears the partial press map and restarts at column 0.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rowMeta_q  <= 4'b1111;
         rowSync_q  <= 4'b1111;
         dwellCnt_q <= '0;
         colIdx_q   <= 2'd0;
         pressMap_q <= 16'd0;
      end else begin
         rowMeta_q  <= row;
         rowSync_q  <= rowMeta_q;
         dwellCnt_q <= dwellCnt_q + SCAN_BITS'(1);
         if (tick) begin
            colIdx_q   <= colIdx_q + 2'd1;
            pressMap_q <= pressMap_d;
         end
      end
   end

   keypad_debounce #(
      .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
   ) uDebounce (
      .clk         (clk),
      .reset       (reset),
      .scanDone_i  (scanDone),
      .snapState_i (snapState),
      .snapCode_i  (snapCode),
      .keyCode_o   (key_code),
      .keyValid_o  (key_valid),
      .keyPress_o  (key_press),
      .keyRelease_o(key_release)
   );

endmodule

// File: tb/tb_keypad_scanner.sv
// -----------------------------------------------------------------------------
// tb_keypad_scanner
// Directed bench for keypad_scanner with a short dwell (16 clk per column,
// 64 clk per scan) and two-scan debounce. A behavioural keypad matrix pulls
// row r low while key (r,c) is held and column c is strobed.
// -----------------------------------------------------------------------------
module tb_keypad_scanner;

   localparam int SCAN     = 64;
   localparam int WAIT_MAX = 3 * SCAN + 3;

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  row;
   logic [3:0]  col;
   logic [3:0]  key_code;
   logic        key_valid;
   logic        key_press;
   logic        key_release;
   logic [15:0] held;

   int testsRun     = 0;
   int testsFailed  = 0;
   int pressCount   = 0;
   int releaseCount = 0;
   int bothCount    = 0;

   keypad_scanner #(
      .SCAN_BITS     (4),
      .DEBOUNCE_SCANS(2)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .row        (row),
      .col        (col),
      .key_code   (key_code),
      .key_valid  (key_valid),
      .key_press  (key_press),
      .key_release(key_release)
   );

   always #5 clk = ~clk;

   // Keypad matrix: a held key shorts its row to its column while that
   // column is driven low; otherwise the pull-up keeps the row high.
   always_comb begin
      row = 4'b1111;
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < 4; c++) begin
            if (held[r * 4 + c] && !col[c]) begin
               row[r] = 1'b0;
            end
         end
      end
   end

   // Pulses last one clock, so sampling mid-cycle counts each exactly once.
   always @(negedge clk) begin
      if (key_press)   pressCount++;
      if (key_release) releaseCount++;
      if (key_press && key_release) bothCount++;
   end

   // Runaway guard in case the bench itself loses its way.
   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout, want completion");
      $fatal(1, "[TB] watchdog expired");
   end

   // Compare one observed value against its expected value.
   task automatic checkOutput(input string tag, input logic [31:0] actual,
                              input logic [31:0] expected);
      testsRun++;
      if (actual !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
      end
   endtask

   // Hold the given key set for a number of clock cycles.
   task automatic applyStimulus(input logic [15:0] keys, input int cycles);
      held = keys;
      repeat (cycles) @(negedge clk);
   endtask

   // Wait, with a bound, until a press (or release) pulse beyond base is seen.
   task automatic waitForPulse(input bit wantRelease, input int base);
      int n = 0;
      while ((((wantRelease ? releaseCount : pressCount) == base)) && (n < WAIT_MAX)) begin
         @(negedge clk);
         n++;
      end
   endtask

   initial begin
      int basePress;
      int baseRelease;

      held  = 16'h0000;
      reset = 1'b1;
      repeat (3) @(negedge clk);
      checkOutput("reset_col",     32'(col), 32'h0000_000E);
      checkOutput("reset_code",    32'(key_code), 32'h0);
      checkOutput("reset_valid",   32'(key_valid), 32'h0);
      checkOutput("reset_press",   32'(key_press), 32'h0);
      checkOutput("reset_release", 32'(key_release), 32'h0);
      reset = 1'b0;

      // Column strobe walks 1110,1101,1011,0111,1110 with 16 clk per step
      begin
         logic [3:0] colSeq [0:4];
         colSeq = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1110};
         repeat (8) @(negedge clk);
         for (int k = 0; k < 5; k++) begin
            checkOutput($sformatf("col_step%0d", k), 32'(col), 32'(colSeq[k]));
            repeat (16) @(negedge clk);
         end
      end

      // Idle for ten scans: nothing may be reported
      applyStimulus(16'h0000, 10 * SCAN);
      checkOutput("idle_press",   32'(pressCount), 32'd0);
      checkOutput("idle_release", 32'(releaseCount), 32'd0);
      checkOutput("idle_valid",   32'(key_valid), 32'h0);

      // Hold '5' (row 1, col 1)
      held = 16'h0020;
      waitForPulse(1'b0, 0);
      checkOutput("k5_press",  32'(pressCount), 32'd1);
      checkOutput("k5_code",   32'(key_code), 32'h5);
      checkOutput("k5_valid",  32'(key_valid), 32'h1);
      applyStimulus(16'h0020, 5 * SCAN);
      checkOutput("k5_hold_press",   32'(pressCount), 32'd1);
      checkOutput("k5_hold_release", 32'(releaseCount), 32'd0);

      // Release '5'
      held = 16'h0000;
      waitForPulse(1'b1, 0);
      checkOutput("k5_release",       32'(releaseCount), 32'd1);
      checkOutput("k5_release_valid", 32'(key_valid), 32'h0);
      checkOutput("k5_release_code",  32'(key_code), 32'h5);
      applyStimulus(16'h0000, 2 * SCAN);
      checkOutput("k5_release_once",  32'(releaseCount), 32'd1);

      // Bounce: '9' (row 2, col 2) visible in at most one scan, three times
      for (int b = 0; b < 3; b++) begin
         applyStimulus(16'h0400, 48);
         applyStimulus(16'h0000, 100);
      end
      checkOutput("bounce_press", 32'(pressCount), 32'd1);
      checkOutput("bounce_valid", 32'(key_valid), 32'h0);

      // Hold '1', then add '2' (ghosting), then drop '1'
      basePress = pressCount;
      held = 16'h0001;
      waitForPulse(1'b0, basePress);
      checkOutput("k1_press", 32'(pressCount - basePress), 32'd1);
      checkOutput("k1_code",  32'(key_code), 32'h1);
      basePress   = pressCount;
      baseRelease = releaseCount;
      applyStimulus(16'h0003, 4 * SCAN);
      checkOutput("multi_press",   32'(pressCount - basePress), 32'd0);
      checkOutput("multi_release", 32'(releaseCount - baseRelease), 32'd0);
      checkOutput("multi_code",    32'(key_code), 32'h1);
      checkOutput("multi_valid",   32'(key_valid), 32'h1);
      held = 16'h0002;
      waitForPulse(1'b0, basePress);
      checkOutput("k2_press",   32'(pressCount - basePress), 32'd1);
      checkOutput("k2_code",    32'(key_code), 32'h2);
      checkOutput("k2_valid",   32'(key_valid), 32'h1);
      checkOutput("k2_release", 32'(releaseCount - baseRelease), 32'd0);
      held = 16'h0000;
      waitForPulse(1'b1, baseRelease);
      checkOutput("k2_drop", 32'(releaseCount - baseRelease), 32'd1);

      // Hold 'A' (row 0, col 3), then pulse reset mid-scan between edges
      basePress = pressCount;
      held = 16'h0008;
      waitForPulse(1'b0, basePress);
      checkOutput("kA_press", 32'(key_code), 32'hA);
      repeat (20) @(negedge clk);
      #2 reset = 1'b1;
      #1;
      checkOutput("async_valid", 32'(key_valid), 32'h0);
      checkOutput("async_code",  32'(key_code), 32'h0);
      checkOutput("async_col",   32'(col), 32'h0000_000E);
      @(negedge clk);
      reset = 1'b0;
      basePress = pressCount;
      waitForPulse(1'b0, basePress);
      checkOutput("kA_repress", 32'(pressCount - basePress), 32'd1);
      checkOutput("kA_code",    32'(key_code), 32'hA);
      checkOutput("kA_valid",   32'(key_valid), 32'h1);
      applyStimulus(16'h0008, 2 * SCAN);
      checkOutput("kA_once",    32'(pressCount - basePress), 32'd1);

      checkOutput("press_release_overlap", 32'(bothCount), 32'd0);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
